// File: rtl/event_unit_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : event_unit_irq_arbiter
// Purpose  : Arbitrates the masked pending interrupt lines of the APB event
//            unit onto a single core interrupt request. Selection is either
//            fixed priority (index 0 highest) or round-robin. The chosen
//            request and ID stay stable until the core acknowledges. A
//            one-hot, one-cycle clear strobe is then returned to the pending
//            register, followed by one idle cycle before the next selection.
// Ports    : HCLK          - clock
//            HRESETn       - synchronous, active-low reset
//            irq_pending_i - pending bits from the IRQ pending register
//            irq_enable_i  - mask bits from the IRQ enable register
//            arb_en_i      - global arbiter enable
//            rr_mode_i     - 0 = fixed priority, 1 = round-robin
//            irq_req_o     - interrupt request to the core
//            irq_id_o      - index of the requested line (valid with irq_req_o)
//            irq_ack_i     - core accepts the current request (one-cycle pulse)
//            irq_clear_o   - one-hot, one-cycle clear strobe to pending register
//            busy_o        - arbiter is not idle
// Revision : 1.0 - initial release
// ============================================================================
module event_unit_irq_arbiter #(
    parameter int NB_IRQ   = 32,
    parameter int ID_WIDTH = $clog2(NB_IRQ)
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic [NB_IRQ-1:0]   irq_pending_i,
    input  logic [NB_IRQ-1:0]   irq_enable_i,
    input  logic                arb_en_i,
    input  logic                rr_mode_i,
    output logic                irq_req_o,
    output logic [ID_WIDTH-1:0] irq_id_o,
    input  logic                irq_ack_i,
    output logic [NB_IRQ-1:0]   irq_clear_o,
    output logic                busy_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [NB_IRQ-1:0]   c_one_hot0 = NB_IRQ'(1);
    localparam logic [ID_WIDTH-1:0] c_last_id  = ID_WIDTH'(NB_IRQ - 1);
    localparam logic [ID_WIDTH-1:0] c_id_one   = ID_WIDTH'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // waiting for an eligible line
        S_REQ  = 2'd1,   // request presented, ID frozen
        S_CLR  = 2'd2,   // clear strobe cycle
        S_GAP  = 2'd3    // let the pending register reflect the clear
    } state_t;

    state_t                r_state;
    logic                  r_irq_req;
    logic [ID_WIDTH-1:0]   r_irq_id;
    logic [NB_IRQ-1:0]     r_irq_clear;
    logic                  r_busy;
    logic [ID_WIDTH-1:0]   r_rr_ptr;

    // ------------------------------------------------------------------------
    // Eligibility
    // ------------------------------------------------------------------------
    logic [NB_IRQ-1:0]     w_cand;
    logic                  w_any_cand;
    logic                  w_cur_valid;

    assign w_cand      = arb_en_i ? (irq_pending_i & irq_enable_i) : '0;
    assign w_any_cand  = |w_cand;
    // Is the line currently being requested still eligible?
    assign w_cur_valid = w_cand[r_irq_id];

    // ------------------------------------------------------------------------
    // Selection
    // ------------------------------------------------------------------------
    // Lowest set index of a vector; returns 0 for an all-zero vector (callers
    // only use the result when the vector is non-zero).
    function automatic logic [ID_WIDTH-1:0] f_lowest_set(input logic [NB_IRQ-1:0] vec);
        logic [ID_WIDTH-1:0] idx;
        idx = '0;
        for (int i = NB_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_WIDTH'(i);
            end
        end
        return idx;
    endfunction

    logic [NB_IRQ-1:0]     w_upper_mask;  // indices at or above r_rr_ptr
    logic [NB_IRQ-1:0]     w_cand_upper;
    logic [ID_WIDTH-1:0]   w_fp_winner;
    logic [ID_WIDTH-1:0]   w_rr_winner;
    logic [ID_WIDTH-1:0]   w_winner;

    always_comb begin
        w_upper_mask = '0;
        for (int i = 0; i < NB_IRQ; i++) begin
            w_upper_mask[i] = (ID_WIDTH'(i) >= r_rr_ptr);
        end
    end

    assign w_cand_upper = w_cand & w_upper_mask;
    assign w_fp_winner  = f_lowest_set(w_cand);

    // Round-robin: search from the pointer upwards first; if nothing is set
    // there, the wrap-around search is just the lowest set index overall.
    assign w_rr_winner  = (|w_cand_upper) ? f_lowest_set(w_cand_upper) : w_fp_winner;
    assign w_winner     = rr_mode_i ? w_rr_winner : w_fp_winner;

    // ------------------------------------------------------------------------
    // Post-grant helpers
    // ------------------------------------------------------------------------
    logic [NB_IRQ-1:0]     w_id_onehot;
    logic [ID_WIDTH-1:0]   w_ptr_next;

    assign w_id_onehot = c_one_hot0 << r_irq_id;
    // Wrap modulo NB_IRQ, which need not be a power of two.
    assign w_ptr_next  = (r_irq_id == c_last_id) ? '0 : (r_irq_id + c_id_one);

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state     <= S_IDLE;
            r_irq_req   <= 1'b0;
            r_irq_id    <= '0;
            r_irq_clear <= '0;
            r_busy      <= 1'b0;
            r_rr_ptr    <= '0;
        end else begin
            // Clear strobe is a single-cycle pulse unless re-armed below.
            r_irq_clear <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_cand) begin
                        r_state   <= S_REQ;
                        r_irq_req <= 1'b1;
                        r_irq_id  <= w_winner;
                        r_busy    <= 1'b1;
                    end
                end
                S_REQ: begin
                    // Ack has priority over a simultaneous withdraw.
                    if (irq_ack_i) begin
                        r_state     <= S_CLR;
                        r_irq_req   <= 1'b0;
                        r_irq_clear <= w_id_onehot;
                        r_rr_ptr    <= w_ptr_next;
                    end else if (!w_cur_valid) begin
                        r_state   <= S_IDLE;
                        r_irq_req <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                end
                S_CLR: begin
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_irq_req <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign irq_req_o   = r_irq_req;
    assign irq_id_o    = r_irq_id;
    assign irq_clear_o = r_irq_clear;
    assign busy_o      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_event_unit_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_event_unit_irq_arbiter
// Purpose  : Self-checking bench for event_unit_irq_arbiter. Directed
//            scenarios followed by randomized traffic, all compared against a
//            transaction-level reference model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_event_unit_irq_arbiter;

    localparam int NB  = 32;
    localparam int IDW = 5;

    logic           HCLK;
    logic           HRESETn;
    logic [NB-1:0]  irq_pending;
    logic [NB-1:0]  irq_enable;
    logic           arb_en;
    logic           rr_mode;
    logic           irq_req;
    logic [IDW-1:0] irq_id;
    logic           irq_ack;
    logic [NB-1:0]  irq_clear;
    logic           busy;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state (transaction view, not the RTL's state machine)
    bit          m_req;
    int          m_id;
    logic [31:0] m_clear;
    int          m_cooldown;  // cycles left before a new selection may start
    int          m_ptr;

    event_unit_irq_arbiter #(
        .NB_IRQ   (NB),
        .ID_WIDTH (IDW)
    ) dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .irq_pending_i (irq_pending),
        .irq_enable_i  (irq_enable),
        .arb_en_i      (arb_en),
        .rr_mode_i     (rr_mode),
        .irq_req_o     (irq_req),
        .irq_id_o      (irq_id),
        .irq_ack_i     (irq_ack),
        .irq_clear_o   (irq_clear),
        .busy_o        (busy)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // First eligible index scanning upwards from start, wrapping modulo NB.
    function automatic int pick(input logic [31:0] c, input int start);
        for (int k = 0; k < NB; k++) begin
            int idx;
            idx = (start + k) % NB;
            if (c[idx]) return idx;
        end
        return 0;
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_update();
        logic [31:0] cand;
        if (!HRESETn) begin
            m_req      = 0;
            m_id       = 0;
            m_clear    = '0;
            m_cooldown = 0;
            m_ptr      = 0;
        end else begin
            cand    = arb_en ? (irq_pending & irq_enable) : 32'd0;
            m_clear = '0;
            if (m_cooldown > 0) begin
                m_cooldown = m_cooldown - 1;
            end else if (m_req) begin
                if (irq_ack) begin
                    m_req      = 0;
                    m_clear    = 32'd1 << m_id;
                    m_ptr      = (m_id + 1) % NB;
                    m_cooldown = 2;
                end else if (!cand[m_id]) begin
                    m_req = 0;
                end
            end else if (cand != 0) begin
                m_req = 1;
                m_id  = rr_mode ? pick(cand, m_ptr) : pick(cand, 0);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // One clock: model follows the edge, outputs compared 1 ns later.
    task automatic step(input string tag);
        @(posedge HCLK);
        model_update();
        #1;
        chk({tag, "_req"},   {31'd0, irq_req},   {31'd0, m_req});
        chk({tag, "_id"},    {27'd0, irq_id},    m_id);
        chk({tag, "_clear"}, irq_clear,          m_clear);
        chk({tag, "_busy"},  {31'd0, busy},      {31'd0, (m_req || m_cooldown != 0)});
    endtask

    // Acknowledge the current request and run through clear + gap to idle.
    task automatic ack_and_drain(input string tag);
        irq_ack = 1'b1;
        step({tag, "_ack"});
        irq_ack = 1'b0;
        step({tag, "_gap"});
        step({tag, "_idle"});
    endtask

    int exp_rr [4] = '{0, 1, 31, 0};

    initial begin
        HRESETn     = 1'b0;
        irq_pending = '1;
        irq_enable  = '1;
        arb_en      = 1'b1;
        rr_mode     = 1'b0;
        irq_ack     = 1'b0;
        m_req = 0; m_id = 0; m_clear = '0; m_cooldown = 0; m_ptr = 0;

        // ---------------- Reset held with everything pending ----------------
        step("rst0");
        step("rst1");
        chk("rst_req_const", {31'd0, irq_req}, 32'd0);
        chk("rst_id_const",  {27'd0, irq_id},  32'd0);

        // Release: request appears one cycle later, then reset mid-request.
        HRESETn = 1'b1;
        step("rel");
        chk("rel_req_const", {31'd0, irq_req}, 32'd1);
        HRESETn = 1'b0;
        step("rst_in_req");
        chk("rst_in_req_req",   {31'd0, irq_req}, 32'd0);
        chk("rst_in_req_clear", irq_clear,        32'd0);
        HRESETn     = 1'b1;
        irq_pending = '0;
        step("settle");

        // ---------------- Fixed priority ----------------
        irq_pending = 32'h0000_0120;
        step("fp_req");
        chk("fp_id_const", {27'd0, irq_id}, 32'd5);
        irq_ack = 1'b1;
        step("fp_ack");
        chk("fp_clear_const", irq_clear, 32'h20);
        irq_ack     = 1'b0;
        irq_pending = 32'h0000_0100;
        step("fp_m2");
        chk("fp_m2_req_const",   {31'd0, irq_req}, 32'd0);
        chk("fp_m2_clear_const", irq_clear,        32'd0);
        step("fp_m3");
        step("fp_next");
        chk("fp_next_id_const", {27'd0, irq_id}, 32'd8);
        irq_pending = '0;
        ack_and_drain("fp8");

        // ---------------- Round-robin from a fresh pointer ----------------
        HRESETn = 1'b0;
        step("rr_rst");
        HRESETn     = 1'b1;
        irq_pending = 32'h8000_0003;
        rr_mode     = 1'b1;
        for (int g = 0; g < 4; g++) begin
            step("rr_req");
            chk("rr_id_const", {27'd0, irq_id}, exp_rr[g]);
            ack_and_drain("rr");
        end
        irq_pending = '0;
        rr_mode     = 1'b0;
        step("rr_done");

        // ---------------- Withdraw and ack-vs-withdraw ----------------
        irq_pending = 32'h8;
        step("wd_req");
        chk("wd_id_const", {27'd0, irq_id}, 32'd3);
        irq_pending = '0;
        step("wd_drop");
        chk("wd_drop_req_const",   {31'd0, irq_req}, 32'd0);
        chk("wd_drop_clear_const", irq_clear,        32'd0);
        irq_pending = 32'h8;
        step("wd_req2");
        irq_pending = '0;
        irq_ack     = 1'b1;
        step("wd_ackwin");
        chk("wd_ackwin_clear_const", irq_clear, 32'h8);
        irq_ack = 1'b0;
        step("wd_gap");
        step("wd_idle");

        // ---------------- Masking / global enable ----------------
        irq_pending = 32'hFF;
        irq_enable  = '0;
        step("mask0");
        step("mask1");
        chk("mask_req_const", {31'd0, irq_req}, 32'd0);
        irq_enable = '1;
        step("mask_req");
        arb_en = 1'b0;
        step("arb_off");
        chk("arb_off_req_const", {31'd0, irq_req}, 32'd0);
        arb_en     = 1'b1;
        irq_enable = 32'h10;
        step("en4");
        chk("en4_id_const", {27'd0, irq_id}, 32'd4);
        irq_pending = '0;
        ack_and_drain("en4");

        // Ack outside REQ is ignored.
        irq_ack = 1'b1;
        step("stray_ack");
        chk("stray_ack_clear_const", irq_clear, 32'd0);
        irq_ack    = 1'b0;
        irq_enable = '1;

        // ---------------- Randomized traffic ----------------
        for (int n = 0; n < 600; n++) begin
            HRESETn = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 3) == 0) begin
                irq_pending = $urandom & $urandom & $urandom;
            end
            if ($urandom_range(0, 15) == 0) begin
                irq_enable = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
            end
            arb_en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 31) == 0) begin
                rr_mode = ~rr_mode;
            end
            irq_ack = ($urandom_range(0, 2) == 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
